// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Optional stall timeout is enabled by defining UART_ARB_TIMEOUT_EN.
package uart_arb_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // Circular successor of a requester index.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// searched in circular order, returned as one-hot and as an index.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_pick,
  output logic [PW-1:0] o_idx
);

  always_comb begin
    int         j;
    logic       found;
    logic [PW-1:0] j_idx;
    // NOTE: every output and temporary gets a default first so no path can infer a latch.
    o_pick = '0;
    o_idx  = '0;
    found  = 1'b0;
    j      = 0;
    j_idx  = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(i_ptr) + k;
      if (j >= N) j = j - N;
      j_idx = PW'(j);
      if (!found && i_req[j_idx]) begin
        found         = 1'b1;
        o_pick[j_idx] = 1'b1;
        o_idx         = j_idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-locked round-robin arbiter feeding one UART transmitter through a byte holding register.
// Define UART_ARB_TIMEOUT_EN to release a stalled lock after TIMEOUT idle owner cycles.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [BYTE_W*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic [BYTE_W-1:0]       tx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic [N_REQ-1:0]        grant,
  output logic                    busy
`ifdef UART_ARB_TIMEOUT_EN
  ,
  output logic                    timeout_err
`endif
);

  localparam int PTR_W = $clog2(N_REQ);

  arb_state_t        r_state;
  logic [PTR_W-1:0]  r_ptr;
  logic [PTR_W-1:0]  r_owner;
  logic [N_REQ-1:0]  r_grant;
  logic [BYTE_W-1:0] r_hold_data;
  logic              r_hold_valid;

  logic [N_REQ-1:0]  w_pick;
  logic [PTR_W-1:0]  w_pick_idx;
  logic [BYTE_W-1:0] w_req_bytes [N_REQ];
  logic [BYTE_W-1:0] w_owner_data;
  logic [PTR_W-1:0]  w_next_ptr;
  logic              w_owner_valid;
  logic              w_owner_last;
  logic              w_can_load;
  logic              w_accept;
  logic              w_tx_xfer;
  logic              w_timeout;
  logic              w_release;

  rr_pick #(
    .N  (N_REQ),
    .PW (PTR_W)
  ) u_rr_pick (
    .i_req  (req_valid),
    .i_ptr  (r_ptr),
    .o_pick (w_pick),
    .o_idx  (w_pick_idx)
  );

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_bytes
    assign w_req_bytes[gi] = req_data[gi*BYTE_W +: BYTE_W];
  end

  assign w_owner_data  = w_req_bytes[r_owner];
  assign w_owner_valid = |(req_valid & r_grant);
  assign w_owner_last  = |(req_last & r_grant);
  assign w_next_ptr    = PTR_W'(wrap_inc(int'(r_owner), N_REQ));

  // The owner may load whenever the holding register is empty or emptying this cycle.
  assign w_can_load = (r_state == LOCKED) && (!r_hold_valid || tx_ready);
  assign w_accept   = w_can_load && w_owner_valid;
  assign w_tx_xfer  = r_hold_valid && tx_ready;
  assign w_release  = (w_accept && w_owner_last) || w_timeout;

  assign req_ready = w_can_load ? r_grant : '0;
  assign tx_data   = r_hold_data;
  assign tx_valid  = r_hold_valid;
  assign grant     = r_grant;
  assign busy      = (r_state == LOCKED) || r_hold_valid;

`ifdef UART_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_stall_cnt;
  logic             r_timeout_err;
  logic             w_stall;

  assign w_stall   = (r_state == LOCKED) && !w_owner_valid;
  assign w_timeout = w_stall && (r_stall_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_stall_cnt   <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_timeout;
      if ((r_state != LOCKED) || w_accept || w_timeout)
        r_stall_cnt <= '0;
      else if (w_stall)
        r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  logic w_unused_timeout;

  assign w_unused_timeout = ^TIMEOUT;
  assign w_timeout        = 1'b0;
`endif

  // The holding register drains on its own, regardless of lock state.
  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_hold_data  <= '0;
      r_hold_valid <= 1'b0;
    end else if (w_accept) begin
      r_hold_data  <= w_owner_data;
      r_hold_valid <= 1'b1;
    end else if (w_tx_xfer) begin
      r_hold_valid <= 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_grant <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|req_valid) begin
            r_state <= LOCKED;
            r_grant <= w_pick;
            r_owner <= w_pick_idx;
          end
        end
        LOCKED: begin
          if (w_release) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_ptr   <= w_next_ptr;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters, range 2..8.
REQ-002 Parameter TIMEOUT, default 255: stall limit in cycles, used only when UART_ARB_TIMEOUT_EN is defined.
REQ-003 CLK  input  1  clock; all state updates on posedge CLK.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 req_data  input  8*N_REQ  byte from requester i in bits [8i+7:8i].
REQ-006 req_valid  input  N_REQ  requester i offers a byte.
REQ-007 req_last  input  N_REQ  offered byte is the final byte of a packet.
REQ-008 req_ready  output  N_REQ  requester i byte accepted this cycle when req_valid[i] is also high.
REQ-009 tx_data  output  8  byte to the UART transmitter.
REQ-010 tx_valid  output  1  tx_data is valid.
REQ-011 tx_ready  input  1  transmitter idle; transfer occurs when tx_valid and tx_ready are both high.
REQ-012 grant  output  N_REQ  one-hot owner of the transmitter; all zero when no owner.
REQ-013 busy  output  1  high in LOCKED or while the holding register is full.
REQ-014 timeout_err  output  1  one-cycle pulse on lock release by timeout; present only with UART_ARB_TIMEOUT_EN.

Function
REQ-015 The FSM SHALL have two states, IDLE and LOCKED, plus a round-robin pointer ptr (0..N_REQ-1) and a one-byte holding register (hold_data, hold_valid).
REQ-016 In IDLE with any req_valid high, the block SHALL select the first requester at or after ptr, in circular order, whose req_valid is high, then set grant to that one-hot value and enter LOCKED on the next edge.
REQ-017 In IDLE, req_ready SHALL be all zero; arbitration costs exactly one cycle.
REQ-018 In LOCKED, req_ready[g] = grant[g] AND (NOT hold_valid OR tx_ready), and all other req_ready bits SHALL be zero.
REQ-019 An accepted byte SHALL load hold_data and set hold_valid on the same edge.
REQ-020 tx_data = hold_data and tx_valid = hold_valid.
REQ-021 hold_valid SHALL clear on a tx transfer unless a new byte is loaded on the same edge.
REQ-022 Latency SHALL be 2 cycles: req_valid rising in IDLE at cycle t gives tx_valid at cycle t+2.
REQ-023 Accepting a byte with req_last high SHALL return the FSM to IDLE, clear grant, and set ptr to the owner index plus 1 modulo N_REQ.
REQ-024 The holding register SHALL drain independently of the FSM state.
REQ-025 The lock SHALL hold across gaps, so no other requester's byte is interleaved within a packet.
REQ-026 A single-byte packet (req_last high on the first byte) SHALL be legal and SHALL release the lock after one byte.
REQ-027 Back-to-back packets from different requesters SHALL be separated by exactly one IDLE cycle.
REQ-028 req_valid deasserted by the owner while LOCKED SHALL NOT release the lock; only the last byte or a timeout releases it.

Reset
REQ-029 RESET high SHALL immediately force: state IDLE, ptr 0, grant 0, hold_valid 0, tx_valid 0, tx_data 0, req_ready 0, busy 0, timeout_err 0.
REQ-030 A packet in progress SHALL be dropped on RESET, including any byte in the holding register.

Configuration
REQ-031 With UART_ARB_TIMEOUT_EN defined, a counter SHALL count LOCKED cycles in which req_valid[owner] is low, and SHALL clear on each accepted byte.
REQ-032 When the counter reaches TIMEOUT, the block SHALL return to IDLE, advance ptr as in REQ-023, and pulse timeout_err for 1 cycle.
REQ-033 Without UART_ARB_TIMEOUT_EN, the counter and timeout_err SHALL be absent and the lock SHALL be held indefinitely.

Structure
REQ-034 Package uart_arb_pkg SHALL hold the state enum (IDLE, LOCKED) and the constant BYTE_W = 8.
REQ-035 Sub-module rr_pick SHALL be combinational: inputs req vector and ptr; outputs one-hot pick and index.

Verification
REQ-036 Single requester: req1 sends 0x55, 0xA3 (last) with tx_ready high -> tx_data 0x55 at t+2 and 0xA3 at t+3; then grant = 0, ptr = 2.
REQ-037 Contention: req0..req3 each offer a 1-byte packet at once with ptr = 0 -> grants 0, 1, 2, 3 in order, each byte on tx exactly once.
REQ-038 Backpressure: tx_ready held low for 10 cycles while locked -> hold register keeps its byte, req_ready[owner] stays 0, no byte is lost or duplicated.
REQ-039 Gap in packet: req2 drops req_valid for 5 cycles mid-packet while req0 is valid -> req0 receives no grant until req2's last byte.
REQ-040 Timeout (macro on, TIMEOUT = 4): owner stalls -> timeout_err pulses on the 4th stall cycle and the next requester is granted.
REQ-041 RESET asserted mid-packet -> all outputs 0 with no clock edge; after release, ptr = 0 and arbitration restarts cleanly.
